scene_ctrl: RTL and testbench
=============================

# scene_ctrl

Frame-level sequencer for the `scene` restoration datapath. It accepts per-frame atmospheric-light triples from the airlight estimator and a valid/ready pixel stream carrying hazy RGB and the 1/t code. It holds the airlight constant for a whole frame and feeds the datapath one pixel per cycle. Results are collected into a small output FIFO so downstream backpressure never corrupts the datapath's fixed 1-cycle pipeline.

## Interface
- FRAME_W, 640, pixels per line
- FRAME_H, 480, lines per frame
- ON_BY_T_MAX, 8'd200, ceiling applied to the 1/t code when clamping is compiled in
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_a_valid / o_a_ready  in/out  1  airlight handshake
- i_ar, i_ag, i_ab  in  8  airlight per channel
- i_px_valid / o_px_ready  in/out  1  input pixel handshake
- i_er, i_eg, i_eb  in  8  hazy pixel
- i_on_by_t  in  8  1/t code, Q0.8 multiplier
- i_sof  in  1  first pixel of frame, qualified by the pixel handshake
- o_dp_er, o_dp_eg, o_dp_eb, o_dp_on_by_t, o_dp_ar, o_dp_ag, o_dp_ab  out  8  registered datapath operands
- i_dp_r, i_dp_g, i_dp_b  in  8  datapath results
- o_valid / i_ready  out/in  1  output handshake
- o_r, o_g, o_b  out  8  restored pixel
- o_eof  out  1  marks the last pixel of the frame on the output
- o_frame_done  out  1  one-cycle pulse
- o_resync  out  1  one-cycle pulse
- o_busy  out  1  high when state is not IDLE or the FIFO is not empty

## Operation
- States:
  - IDLE: o_a_ready=1, o_px_ready=0. On an airlight handshake, latch the triple into the frame registers, zero the col/row counters, and go to RUN.
  - RUN: o_a_ready=0, o_px_ready = (fifo_count + inflight < 4). Each accepted pixel loads the o_dp_* operand registers, advances col, and advances row when col wraps at FRAME_W-1. Accepting the pixel at (FRAME_W-1, FRAME_H-1) tags it EOF and moves to DRAIN.
  - DRAIN: o_px_ready=0. Go to IDLE when inflight==0.
- In-flight tracking: a 2-stage valid/EOF shift register mirrors the datapath latency. The second stage pushes {i_dp_*, eof} into the 4-deep output FIFO.
- o_dp_ar/ag/ab change only in IDLE. They stay constant for every pixel of a frame.
- Resync: i_sof on an accepted pixel that is not at position (0,0) treats that pixel as (0,0) and pulses o_resync. i_sof is ignored at (0,0).
- Next airlight: an airlight offer arriving during RUN/DRAIN is held off (o_a_ready=0). It is taken in IDLE, so frame N+1 may start while frame N is still draining the FIFO.
- o_frame_done pulses in the cycle the EOF-tagged entry completes the output handshake.
- Arithmetic: the controller never modifies pixel values. The only exception is the 1/t clamp described under Configuration.

## Timing
- Reset values: o_a_ready=0, o_px_ready=0, o_valid=0, o_eof=0, o_frame_done=0, o_resync=0, o_busy=0, all 8-bit outputs 0. State is IDLE, FIFO empty, counters 0. o_a_ready rises on the first edge after reset release.
- Latency: pixel accepted at edge k → operands valid after edge k → datapath captures at edge k+1 → FIFO write at edge k+2 → o_valid high after edge k+2 if the FIFO was empty.
- Throughput: 1 pixel/cycle while i_ready=1.
- The credit check uses registered counts only. A pop in the same cycle does not free a credit until the next cycle.
- FIFO full: impossible by construction. An assertion checks that a push never occurs when full.
- o_valid/o_r/o_g/o_b/o_eof hold stable until i_ready=1.
- Simultaneous FIFO push and pop leaves the count unchanged.
- Reset mid-frame flushes the FIFO, in-flight stages, counters and airlight. No o_frame_done is issued for the aborted frame.

## Configuration
- TMIN_CLAMP_EN defined: o_dp_on_by_t = min(i_on_by_t, ON_BY_T_MAX). This bounds haze amplification in thin-transmission regions.
- TMIN_CLAMP_EN undefined: i_on_by_t passes through unchanged, and ON_BY_T_MAX is unused.

## Structure
- The `scene_pkg` package holds:
  - the state enum (IDLE, RUN, DRAIN)
  - the FIFO_DEPTH=4 and DP_LATENCY=2 constants
  - the packed output entry type {r,g,b,eof}
- Sub-module `scene_out_fifo`: a 4-deep synchronous FIFO with count output. The datapath itself is instantiated beside this block at the top level.

## Test plan
- Reset, then airlight (200,190,180), then a 4x2 frame (FRAME_W=4, FRAME_H=2) with i_ready=1 → 8 outputs in order, first o_valid 3 edges after the first acceptance, o_eof and o_frame_done on the 8th.
- Hold i_ready=0 throughout → o_px_ready falls after 4 accepted pixels, with no loss or reorder once i_ready returns.
- Assert i_sof on the 3rd pixel of a frame → o_resync pulses once, the frame ends 8 pixels after that point, and the EOF tag is on the correct pixel.
- Offer the next airlight (50,50,50) during DRAIN → not accepted until IDLE. All pixels of frame 1 keep o_dp_ar=200.
- With TMIN_CLAMP_EN, i_on_by_t=255 → o_dp_on_by_t=200. Without the macro → 255.
- Assert i_rst after 3 accepted pixels → all outputs 0 immediately, o_frame_done never pulses, and o_a_ready is 1 on the first edge after release.

Source files
------------

// File: rtl/scene_pkg.sv
`default_nettype none
// ============================================================================
// Module : scene_pkg
// Brief  : Shared types and constants for the scene frame sequencer.
// Rev    : 1.0
// ============================================================================
package scene_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int DP_LATENCY = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       eof;
  } out_entry_t;

endpackage
`default_nettype wire

// File: rtl/scene_if.sv
`default_nettype none
// ============================================================================
// Module : scene_if
// Brief  : Airlight, pixel, datapath and output handshake bundle.
// Rev    : 1.0
// ============================================================================
interface scene_if;

  logic       i_a_valid;
  logic       o_a_ready;
  logic [7:0] i_ar, i_ag, i_ab;

  logic       i_px_valid;
  logic       o_px_ready;
  logic [7:0] i_er, i_eg, i_eb;
  logic [7:0] i_on_by_t;
  logic       i_sof;

  logic [7:0] o_dp_er, o_dp_eg, o_dp_eb, o_dp_on_by_t;
  logic [7:0] o_dp_ar, o_dp_ag, o_dp_ab;
  logic [7:0] i_dp_r, i_dp_g, i_dp_b;

  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_r, o_g, o_b;
  logic       o_eof;

  logic       o_frame_done;
  logic       o_resync;
  logic       o_busy;

  // Controller side
  modport slave (
    input  i_a_valid, i_ar, i_ag, i_ab,
    output o_a_ready,
    input  i_px_valid, i_er, i_eg, i_eb, i_on_by_t, i_sof,
    output o_px_ready,
    output o_dp_er, o_dp_eg, o_dp_eb, o_dp_on_by_t, o_dp_ar, o_dp_ag, o_dp_ab,
    input  i_dp_r, i_dp_g, i_dp_b,
    output o_valid, o_r, o_g, o_b, o_eof,
    input  i_ready,
    output o_frame_done, o_resync, o_busy
  );

  // Environment side (sources, datapath, sink)
  modport master (
    output i_a_valid, i_ar, i_ag, i_ab,
    input  o_a_ready,
    output i_px_valid, i_er, i_eg, i_eb, i_on_by_t, i_sof,
    input  o_px_ready,
    input  o_dp_er, o_dp_eg, o_dp_eb, o_dp_on_by_t, o_dp_ar, o_dp_ag, o_dp_ab,
    output i_dp_r, i_dp_g, i_dp_b,
    input  o_valid, o_r, o_g, o_b, o_eof,
    output i_ready,
    input  o_frame_done, o_resync, o_busy
  );

endinterface
`default_nettype wire

// File: rtl/scene_out_fifo.sv
`default_nettype none
// ============================================================================
// Module : scene_out_fifo
// Brief  : Small synchronous output FIFO with occupancy count.
// Rev    : 1.0
// ============================================================================
module scene_out_fifo
  import scene_pkg::*;
(
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  push,
  input  wire out_entry_t            din,
  input  wire logic                  pop,
  output out_entry_t                 dout,
  output logic                       empty,
  output logic [FIFO_CNT_W-1:0]      count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  out_entry_t       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is reset so the head reads as zero while empty after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule
`default_nettype wire

// File: rtl/scene_ctrl.sv
`default_nettype none
// ============================================================================
// Module : scene_ctrl
// Brief  : Frame sequencer feeding the scene datapath; optional 1/t ceiling
//          compiled in with macro TMIN_CLAMP_EN.
// Rev    : 1.0
// ============================================================================
module scene_ctrl
  import scene_pkg::*;
#(
  parameter int         FRAME_W     = 640,
  parameter int         FRAME_H     = 480,
  parameter logic [7:0] ON_BY_T_MAX = 8'd200
) (
  input wire logic i_clk,
  input wire logic i_rst,
  scene_if.slave   bus
);

  localparam int COL_W  = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int ROW_W  = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam int INFL_W = $clog2(DP_LATENCY + 1);
  localparam int SUM_W  = FIFO_CNT_W + 1;

`ifdef TMIN_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  state_t                 state, state_next;
  logic                   armed;
  logic [COL_W-1:0]       col, eff_col, col_next;
  logic [ROW_W-1:0]       row, eff_row, row_next;
  logic [DP_LATENCY-1:0]  fl_v, fl_eof;
  logic [INFL_W-1:0]      inflight_cnt;
  logic [FIFO_CNT_W-1:0]  fifo_count;
  logic                   credit_ok;
  logic                   a_ready, px_ready, a_acc, px_acc;
  logic                   resync_px, col_wrap, eof_px, resync;
  logic [7:0]             on_by_t_in;
  logic [7:0]             dp_er, dp_eg, dp_eb, dp_on_by_t, dp_ar, dp_ag, dp_ab;
  out_entry_t             fifo_din, fifo_dout;
  logic                   fifo_empty;

  assign on_by_t_in = (CLAMP_EN && (bus.i_on_by_t > ON_BY_T_MAX)) ? ON_BY_T_MAX : bus.i_on_by_t;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < DP_LATENCY; i++) inflight_cnt = inflight_cnt + INFL_W'(fl_v[i]);
  end

  // Credits come from registered state only, so a same-cycle pop frees nothing
  assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(inflight_cnt)) < SUM_W'(FIFO_DEPTH);

  // An sof away from the origin re-anchors this pixel as (0,0)
  assign resync_px = bus.i_sof && !((col == '0) && (row == '0));
  assign eff_col   = resync_px ? '0 : col;
  assign eff_row   = resync_px ? '0 : row;
  assign col_wrap  = (eff_col == COL_W'(FRAME_W - 1));
  assign eof_px    = col_wrap && (eff_row == ROW_W'(FRAME_H - 1));
  assign col_next  = col_wrap ? '0 : eff_col + 1'b1;
  assign row_next  = !col_wrap ? eff_row :
                     (eff_row == ROW_W'(FRAME_H - 1)) ? '0 : eff_row + 1'b1;

  always_comb begin
    state_next = state;
    a_ready    = 1'b0;
    px_ready   = 1'b0;
    case (state)
      IDLE: begin
        a_ready = armed;
        if (armed && bus.i_a_valid) state_next = RUN;
      end
      RUN: begin
        px_ready = credit_ok;
        if (bus.i_px_valid && credit_ok && eof_px) state_next = DRAIN;
      end
      DRAIN: begin
        if (inflight_cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign a_acc  = a_ready && bus.i_a_valid;
  assign px_acc = px_ready && bus.i_px_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      armed      <= 1'b0;
      col        <= '0;
      row        <= '0;
      fl_v       <= '0;
      fl_eof     <= '0;
      resync     <= 1'b0;
      dp_er      <= '0;
      dp_eg      <= '0;
      dp_eb      <= '0;
      dp_on_by_t <= '0;
      dp_ar      <= '0;
      dp_ag      <= '0;
      dp_ab      <= '0;
    end else begin
      state  <= state_next;
      armed  <= 1'b1;
      fl_v   <= {fl_v[DP_LATENCY-2:0], px_acc};
      fl_eof <= {fl_eof[DP_LATENCY-2:0], px_acc && eof_px};
      resync <= px_acc && resync_px;
      if (a_acc) begin
        dp_ar <= bus.i_ar;
        dp_ag <= bus.i_ag;
        dp_ab <= bus.i_ab;
        col   <= '0;
        row   <= '0;
      end
      if (px_acc) begin
        dp_er      <= bus.i_er;
        dp_eg      <= bus.i_eg;
        dp_eb      <= bus.i_eb;
        dp_on_by_t <= on_by_t_in;
        col        <= col_next;
        row        <= row_next;
      end
    end
  end

  assign fifo_din = '{r: bus.i_dp_r, g: bus.i_dp_g, b: bus.i_dp_b, eof: fl_eof[DP_LATENCY-1]};

  scene_out_fifo u_out_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (fl_v[DP_LATENCY-1]),
    .din   (fifo_din),
    .pop   (bus.i_ready),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.o_a_ready    = a_ready;
  assign bus.o_px_ready   = px_ready;
  assign bus.o_dp_er      = dp_er;
  assign bus.o_dp_eg      = dp_eg;
  assign bus.o_dp_eb      = dp_eb;
  assign bus.o_dp_on_by_t = dp_on_by_t;
  assign bus.o_dp_ar      = dp_ar;
  assign bus.o_dp_ag      = dp_ag;
  assign bus.o_dp_ab      = dp_ab;
  assign bus.o_valid      = !fifo_empty;
  assign bus.o_r          = fifo_dout.r;
  assign bus.o_g          = fifo_dout.g;
  assign bus.o_b          = fifo_dout.b;
  assign bus.o_eof        = fifo_dout.eof;
  assign bus.o_frame_done = !fifo_empty && bus.i_ready && fifo_dout.eof;
  assign bus.o_resync     = resync;
  assign bus.o_busy       = (state != IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_scene_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_scene_ctrl
// Brief  : Directed self-checking bench for scene_ctrl on a 4x2 frame.
// Rev    : 1.0
// ============================================================================
module tb_scene_ctrl;

`ifdef TMIN_CLAMP_EN
  localparam logic [7:0] EXP_OBT = 8'd200;
`else
  localparam logic [7:0] EXP_OBT = 8'd255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scene_if bus ();

  scene_ctrl #(
    .FRAME_W     (4),
    .FRAME_H     (2),
    .ON_BY_T_MAX (8'd200)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Stand-in datapath with a one-cycle register stage
  always @(posedge clk) begin
    bus.i_dp_r <= bus.o_dp_er;
    bus.i_dp_g <= bus.o_dp_eg + bus.o_dp_on_by_t;
    bus.i_dp_b <= bus.o_dp_eb + bus.o_dp_ar;
  end

  logic [25:0] seen [$];
  int resync_cnt = 0;
  int done_cnt   = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_valid && bus.i_ready)
        seen.push_back({bus.o_r, bus.o_g, bus.o_b, bus.o_eof, bus.o_frame_done});
      if (bus.o_resync) resync_cnt++;
      if (bus.o_frame_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input int n, input logic sof, input logic [7:0] obt);
    int w = 0;
    bus.i_er       = 8'(n + 1);
    bus.i_eg       = 8'(8'h20 + n);
    bus.i_eb       = 8'(8'h40 + n);
    bus.i_on_by_t  = obt;
    bus.i_sof      = sof;
    bus.i_px_valid = 1'b1;
    #1;
    while (!bus.o_px_ready && w < 50) begin tick(); w++; end
    if (w >= 50) begin
      vectors++; miscompares++;
      $error("FAIL px_timeout observed=stalled expected=accepted");
    end
    tick();
    bus.i_px_valid = 1'b0;
    bus.i_sof      = 1'b0;
  endtask

  task automatic offer_a(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int w = 0;
    bus.i_ar = r; bus.i_ag = g; bus.i_ab = b;
    bus.i_a_valid = 1'b1;
    #1;
    while (!bus.o_a_ready && w < 50) begin tick(); w++; end
    if (w >= 50) begin
      vectors++; miscompares++;
      $error("FAIL a_timeout observed=stalled expected=accepted");
    end
    tick();
    bus.i_a_valid = 1'b0;
  endtask

  // Output n of a frame: r=n+1, g=0x20+n, b=0x40+n+airlight, eof/done on last
  task automatic check_frame(input int base, input int npx, input int b_off);
    logic [25:0] expv;
    check("frame_len", 32'(seen.size() - base), 32'(npx));
    for (int n = 0; n < npx; n++) begin
      if (base + n < seen.size()) begin
        expv = {8'(n + 1), 8'(8'h20 + n), 8'(b_off + n), (n == npx - 1), (n == npx - 1)};
        check($sformatf("out%0d", n), 32'(seen[base + n]), 32'(expv));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, d0, r0;
    bus.i_a_valid = 0; bus.i_ar = 0; bus.i_ag = 0; bus.i_ab = 0;
    bus.i_px_valid = 0; bus.i_er = 0; bus.i_eg = 0; bus.i_eb = 0;
    bus.i_on_by_t = 0; bus.i_sof = 0; bus.i_ready = 1;

    // Reset state
    repeat (3) tick();
    check("rst_a_ready", bus.o_a_ready, 0);
    check("rst_px_ready", bus.o_px_ready, 0);
    check("rst_valid", bus.o_valid, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_dp", {bus.o_dp_er, bus.o_dp_ar, bus.o_dp_on_by_t, bus.o_r}, 0);
    rst = 1'b0;
    check("rel_a_ready_low", bus.o_a_ready, 0);
    tick();
    check("rel_a_ready_high", bus.o_a_ready, 1);

    // Frame 1, free-flowing output
    offer_a(8'd200, 8'd190, 8'd180);
    check("a1_latch", {bus.o_dp_ar, bus.o_dp_ag, bus.o_dp_ab}, {8'd200, 8'd190, 8'd180});
    check("a1_ready_low", bus.o_a_ready, 0);
    check("a1_busy", bus.o_busy, 1);
    base = seen.size();
    d0   = done_cnt;
    send(0, 0, 0);
    check("lat_edge1", bus.o_valid, 0);
    check("dp_er0", bus.o_dp_er, 1);
    send(1, 0, 0);
    check("lat_edge2", bus.o_valid, 0);
    send(2, 0, 0);
    check("lat_edge3", {bus.o_valid, bus.o_r}, {1'b1, 8'd1});
    for (int n = 3; n < 8; n++) send(n, 0, 0);
    check("f1_drain_px_ready", bus.o_px_ready, 0);
    repeat (6) tick();
    check_frame(base, 8, 8);
    check("f1_done_cnt", 32'(done_cnt - d0), 1);
    check("f1_idle", {bus.o_a_ready, bus.o_busy}, 2'b10);

    // Frame 2: backpressure, then next airlight offered during drain
    offer_a(8'd200, 8'd190, 8'd180);
    bus.i_ready = 1'b0;
    base = seen.size();
    for (int n = 0; n < 4; n++) send(n, 0, 0);
    check("bp_px_ready", bus.o_px_ready, 0);
    check("bp_head", {bus.o_valid, bus.o_r, bus.o_eof}, {1'b1, 8'd1, 1'b0});
    repeat (3) tick();
    check("bp_hold", {bus.o_px_ready, bus.o_valid, bus.o_r}, {1'b0, 1'b1, 8'd1});
    check("bp_no_pop", 32'(seen.size() - base), 0);
    bus.i_ready = 1'b1;
    for (int n = 4; n < 8; n++) send(n, 0, 0);
    bus.i_ar = 8'd50; bus.i_ag = 8'd50; bus.i_ab = 8'd50;
    bus.i_a_valid = 1'b1;
    #1;
    check("drain_a_held", bus.o_a_ready, 0);
    check("drain_ar_kept", bus.o_dp_ar, 200);
    offer_a(8'd50, 8'd50, 8'd50);
    check("a2_latch", bus.o_dp_ar, 50);
    repeat (6) tick();
    check_frame(base, 8, 8);

    // Frame 3: sof at origin ignored, sof on 3rd pixel re-anchors
    base = seen.size();
    d0   = done_cnt;
    r0   = resync_cnt;
    send(0, 1, 0);
    check("sof_origin", bus.o_resync, 0);
    send(1, 0, 0);
    send(2, 1, 0);
    check("resync_pulse", bus.o_resync, 1);
    send(3, 0, 0);
    check("resync_once", bus.o_resync, 0);
    for (int n = 4; n < 10; n++) send(n, 0, 0);
    check("f3_drain_px_ready", bus.o_px_ready, 0);
    repeat (6) tick();
    check_frame(base, 10, 114);
    check("f3_resync_cnt", 32'(resync_cnt - r0), 1);
    check("f3_done_cnt", 32'(done_cnt - d0), 1);

    // Frame 4: 1/t ceiling, then reset mid-frame
    offer_a(8'd10, 8'd20, 8'd30);
    send(0, 0, 8'd255);
    check("obt_clamp", bus.o_dp_on_by_t, 32'(EXP_OBT));
    send(1, 0, 0);
    send(2, 0, 0);
    d0  = done_cnt;
    rst = 1'b1;
    #1;
    check("mid_rst_out", {bus.o_valid, bus.o_eof, bus.o_r, bus.o_frame_done}, 0);
    check("mid_rst_dp", {bus.o_dp_er, bus.o_dp_ar, bus.o_dp_on_by_t}, 0);
    check("mid_rst_ctl", {bus.o_a_ready, bus.o_px_ready, bus.o_busy, bus.o_resync}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_a_ready", bus.o_a_ready, 1);
    check("post_rst_idle", {bus.o_valid, bus.o_busy, bus.o_px_ready}, 0);
    repeat (4) tick();
    check("post_rst_no_done", 32'(done_cnt - d0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
